// File: rtl/cic_decim_ctrl.sv
// rtl/cic_decim_ctrl.sv - CIC decimator sequencer: integrator gating, comb strobes, start-up discard, output handshake
module cic_decim_ctrl #(
  parameter int N_STAGES   = 3,
  parameter int RATE_W     = 8,
  parameter int OUT_W      = 32,
  parameter int RESET_RATE = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [RATE_W-1:0] cfg_rate,
  input  logic              cfg_load,
  output logic              cfg_err,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              integ_ena,
  output logic              comb_ena,
  output logic              dp_clear,
  input  logic [OUT_W-1:0]  comb_data,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_FILL  = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  localparam int FILL_W = $clog2(N_STAGES + 1);

  logic [2:0]        state;
  logic [RATE_W-1:0] rate_q;
  logic [RATE_W-1:0] phase;
  logic [1:0]        pending;
  logic [FILL_W-1:0] fill_cnt;
  logic              capture;
  logic              last_phase;
  logic              accept;
  logic              dec;
  logic              fill_done;

  assign last_phase = (phase == (rate_q - RATE_W'(1)));
  assign fill_done  = (fill_cnt == FILL_W'(N_STAGES));

  // A period-completing sample waits until the single output slot and the capture pipe are both empty.
  always_comb begin
    in_ready = 1'b0;
    if ((state == S_FILL || state == S_RUN) && enable)
      in_ready = !(last_phase && (out_valid || pending != 2'd0));
  end

  assign accept    = in_valid & in_ready;
  assign integ_ena = accept;
  assign dec       = accept & last_phase;
  assign dp_clear  = (state == S_CLEAR);
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      rate_q    <= RATE_W'(RESET_RATE);
      phase     <= '0;
      pending   <= '0;
      fill_cnt  <= '0;
      capture   <= 1'b0;
      comb_ena  <= 1'b0;
      cfg_err   <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      if (cfg_load) begin
        if (state == S_IDLE && cfg_rate != '0)
          rate_q <= cfg_rate;
        else
          cfg_err <= 1'b1;
      end

      // comb_ena gives the integrators a cycle to settle; capture gives the comb chain one more.
      comb_ena <= dec;
      capture  <= comb_ena;

      if (accept)
        phase <= last_phase ? '0 : phase + RATE_W'(1);

      case ({dec, capture})
        2'b10:   pending <= pending + 2'd1;
        2'b01:   pending <= pending - 2'd1;
        default: pending <= pending;
      endcase

      if (capture && fill_done) begin
        out_data  <= comb_data;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (capture && !fill_done)
        fill_cnt <= fill_cnt + FILL_W'(1);

      case (state)
        S_IDLE: begin
          if (enable)
            state <= S_CLEAR;
        end
        S_CLEAR: begin
          phase    <= '0;
          pending  <= '0;
          fill_cnt <= '0;
          state    <= S_FILL;
        end
        S_FILL: begin
          if (!enable)
            state <= S_DRAIN;
          else if (fill_done)
            state <= S_RUN;
        end
        S_RUN: begin
          if (!enable)
            state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (pending == 2'd0)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cic_decim_ctrl.sv
// tb/tb_cic_decim_ctrl.sv - directed self-checking bench for cic_decim_ctrl
module tb_cic_decim_ctrl;

  localparam logic [31:0] BASE = 32'hA500_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic [7:0]  cfg_rate;
  logic        cfg_load;
  logic        cfg_err;
  logic        in_valid;
  logic        in_ready;
  logic        integ_ena;
  logic        comb_ena;
  logic        dp_clear;
  logic [31:0] comb_data;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  logic [15:0] comb_cnt;
  int          nvec = 0;
  int          nerr = 0;

  cic_decim_ctrl #(.N_STAGES(3), .RATE_W(8), .OUT_W(32), .RESET_RATE(8)) dut (
    .clock(clock), .reset(reset), .enable(enable), .cfg_rate(cfg_rate),
    .cfg_load(cfg_load), .cfg_err(cfg_err), .in_valid(in_valid), .in_ready(in_ready),
    .integ_ena(integ_ena), .comb_ena(comb_ena), .dp_clear(dp_clear), .comb_data(comb_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  always #5 clock = ~clock;

  // Stand-in comb chain: output is the number of comb strobes since the last clear.
  always @(posedge clock) begin
    if (reset || dp_clear) comb_cnt <= '0;
    else if (comb_ena)     comb_cnt <= comb_cnt + 16'd1;
  end
  assign comb_data = BASE | {16'd0, comb_cnt};

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".in_ready"},  32'(in_ready),  32'd0);
    check({tag, ".integ_ena"}, 32'(integ_ena), 32'd0);
    check({tag, ".comb_ena"},  32'(comb_ena),  32'd0);
    check({tag, ".dp_clear"},  32'(dp_clear),  32'd0);
    check({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    check({tag, ".out_data"},  out_data,       32'd0);
    check({tag, ".busy"},      32'(busy),      32'd0);
    check({tag, ".cfg_err"},   32'(cfg_err),   32'd0);
  endtask

  task automatic drain_to_idle(input string tag);
    int n;
    enable    = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (busy && n < 20) begin
      cyc();
      n++;
    end
    check({tag, ".idle"}, 32'(busy), 32'd0);
    cyc();
    cyc();
    check({tag, ".slot_empty"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int acc, acc16_cyc, out_cyc, cycle, nclr, n, nout;
    logic exp_comb, seen;
    logic [31:0] got [3];

    reset = 1'b1; enable = 1'b0; cfg_rate = '0; cfg_load = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    cyc();
    cyc();
    check_quiet("reset");
    check("reset.rate_q", 32'(dut.rate_q), 32'd8);
    reset = 1'b0;

    // Configuration: zero ratio rejected, legal ratio taken in IDLE
    cfg_load = 1'b1; cfg_rate = 8'd0;
    cyc();
    cfg_load = 1'b0;
    check("cfg0.err", 32'(cfg_err), 32'd1);
    check("cfg0.rate_kept", 32'(dut.rate_q), 32'd8);
    cyc();
    check("cfg0.err_pulse", 32'(cfg_err), 32'd0);
    cfg_load = 1'b1; cfg_rate = 8'd4;
    cyc();
    cfg_load = 1'b0;
    check("cfg4.err", 32'(cfg_err), 32'd0);
    check("cfg4.rate", 32'(dut.rate_q), 32'd4);

    // R=4 continuous input: clear once, strobe every 4th accept, first 3 outputs discarded
    enable = 1'b1;
    acc = 0; acc16_cyc = -100; out_cyc = -1; cycle = 0; nclr = 0; seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      if (in_ready) begin
        acc++;
        if (acc == 16) acc16_cyc = cycle;
      end
      if (dp_clear) nclr++;
      exp_comb = in_ready && (acc % 4 == 0);
      cyc();
      cycle++;
      check("r4.comb_ena", 32'(comb_ena), 32'(exp_comb));
      if (out_valid) begin
        seen = 1'b1;
        out_cyc = cycle;
      end
    end
    check("r4.out_seen", 32'(seen), 32'd1);
    check("r4.clear_count", 32'(nclr), 32'd1);
    check("r4.latency", 32'(out_cyc - acc16_cyc), 32'd3);
    check("r4.first_out", out_data, BASE + 32'd4);

    // Ratio change while running is refused
    cfg_load = 1'b1; cfg_rate = 8'd5;
    cyc();
    cfg_load = 1'b0;
    check("cfg_run.err", 32'(cfg_err), 32'd1);
    check("cfg_run.rate_kept", 32'(dut.rate_q), 32'd4);

    // Drop enable the cycle after the next decimating accept
    n = 0;
    while (!comb_ena && n < 20) begin
      cyc();
      n++;
    end
    check("drain.comb_seen", 32'(comb_ena), 32'd1);
    enable = 1'b0; out_ready = 1'b0;
    #1;
    check("drain.in_ready", 32'(in_ready), 32'd0);
    check("drain.busy_d1", 32'(busy), 32'd1);
    cyc();
    check("drain.busy_d2", 32'(busy), 32'd1);
    check("drain.in_ready_d2", 32'(in_ready), 32'd0);
    cyc();
    check("drain.last_valid", 32'(out_valid), 32'd1);
    check("drain.last_data", out_data, BASE + 32'd5);
    check("drain.busy_d3", 32'(busy), 32'd1);
    cyc();
    check("drain.busy_fall", 32'(busy), 32'd0);
    check("drain.valid_held_idle", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    cyc();
    check("drain.consumed", 32'(out_valid), 32'd0);

    // R=1: every accept decimates, in_ready 1,0,0 through fill, no outputs lost
    cfg_load = 1'b1; cfg_rate = 8'd1;
    cyc();
    cfg_load = 1'b0;
    check("cfg1.err", 32'(cfg_err), 32'd0);
    enable = 1'b1;
    cyc();
    check("r1.dp_clear", 32'(dp_clear), 32'd1);
    check("r1.clear_in_ready", 32'(in_ready), 32'd0);
    cyc();
    for (int k = 0; k < 9; k++) begin
      check("r1.in_ready_pattern", 32'(in_ready), (k % 3 == 0) ? 32'd1 : 32'd0);
      cyc();
    end
    nout = 0;
    for (int i = 0; i < 40 && nout < 3; i++) begin
      if (out_valid) begin
        got[nout] = out_data;
        nout++;
      end
      if (nout < 3) cyc();
    end
    check("r1.out_count", 32'(nout), 32'd3);
    check("r1.out0", got[0], BASE + 32'd4);
    check("r1.out1", got[1], BASE + 32'd5);
    check("r1.out2", got[2], BASE + 32'd6);
    drain_to_idle("r1");

    // R=2 with a back-pressured consumer
    cfg_load = 1'b1; cfg_rate = 8'd2;
    cyc();
    cfg_load = 1'b0;
    enable = 1'b1;
    n = 0;
    while (!out_valid && n < 40) begin
      cyc();
      n++;
    end
    check("r2.first_valid", 32'(out_valid), 32'd1);
    check("r2.first_data", out_data, BASE + 32'd4);
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("r2.stall_in_ready", 32'(in_ready), 32'd0);
      check("r2.stall_phase", 32'(dut.phase), 32'd1);
      check("r2.held_data", out_data, BASE + 32'd4);
      cyc();
    end
    out_ready = 1'b1;
    cyc();
    check("r2.released", 32'(out_valid), 32'd0);
    check("r2.stalled_accept", 32'(in_ready), 32'd1);
    n = 0;
    while (!out_valid && n < 20) begin
      cyc();
      n++;
    end
    check("r2.second_valid", 32'(out_valid), 32'd1);
    check("r2.second_data", out_data, BASE + 32'd5);

    // Reset with a capture in flight
    n = 0;
    while (!comb_ena && n < 20) begin
      cyc();
      n++;
    end
    check("rst.comb_seen", 32'(comb_ena), 32'd1);
    check("rst.pending", 32'(dut.pending), 32'd1);
    reset = 1'b1; enable = 1'b0;
    cyc();
    check_quiet("rst");
    reset = 1'b0;
    nout = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (out_valid) nout++;
    end
    check("rst.no_late_output", 32'(nout), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
